approx_mul_arbiter: RTL

- Shares one combinational approx_multiplier (WIDTH x WIDTH -> 2*WIDTH) among NUM_REQ requesters.
- Fair round-robin arbitration and a valid/ready request handshake.
- Registers operands and result, and returns each result with the requester ID on a single response channel with backpressure.
- Sits between the requesting datapath units and the multiplier instance; it is the multiplier's only driver.

---
 rtl/approx_mul_pkg.sv | 19 +
 rtl/approx_multiplier.sv | 25 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/approx_mul_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and defaults for the approximate-multiplier arbiter slice.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  // Width of a requester index; a single bit is kept as the floor so the
  // index port never collapses to zero width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/approx_multiplier.sv
// Shared approximate unsigned multiplier: partial-product bits whose column
// weight is below WIDTH/2 are dropped, the rest are summed exactly.
module approx_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] result
);

  localparam int TRUNC = WIDTH / 2;

  // Accumulate every kept partial-product bit at its column weight.
  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j >= TRUNC) begin
          result = result + ((2*WIDTH)'(A[i] & B[j]) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts one past the pointer and the first
// asserted request wins. Grant is one-hot and is empty when disabled.
module rr_arbiter
  import approx_mul_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o
);

  int             cand;
  logic [IDW-1:0] cand_idx;
  logic           found;

  // Walk the requesters in rotation order after the pointer and take the first valid one.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_i) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (en_i && !found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Shares one approx_multiplier among NUM_REQ requesters: round-robin grant,
// registered operands, registered result returned with the owner's ID.
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int CNT_W   = 16,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       op_id_q;
  logic [WIDTH-1:0]     op_a_q, op_b_q;
  logic [IDW-1:0]       rsp_id_q;
  logic [2*WIDTH-1:0]   rsp_data_q;
  logic                 rsp_valid_q;
  logic [CNT_W-1:0]     op_count_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_idx;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic [2*WIDTH-1:0]   mul_res;
  logic                 rsp_hs;
  logic                 grant_en;
  logic                 take;

  // A new grant is only offered when idle or when the pending response leaves this cycle.
  assign rsp_hs   = (state_q == RESP) && rsp_ready;
  assign grant_en = !rst && ((state_q == IDLE) || rsp_hs);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (grant_en),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign req_ready = grant;
  assign take      = |grant;
  assign sel_a     = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b     = req_b[grant_idx*WIDTH +: WIDTH];

  approx_multiplier #(.WIDTH(WIDTH)) u_mul (
    .A      (op_a_q),
    .B      (op_b_q),
    .result (mul_res)
  );

  // Next-state selection for the IDLE -> MUL -> RESP operation cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (rsp_hs) state_d = take ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on grant, result capture after MUL, response retire and counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (take) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        op_id_q  <= grant_idx;
        rr_ptr_q <= grant_idx;
      end
      if (state_q == MUL) begin
        rsp_data_q  <= mul_res;
        rsp_id_q    <= op_id_q;
        rsp_valid_q <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule
